// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: key codes, scan-result
// encoding, accept-FSM states and the (row, col) to key-code map.
package keypad_pkg;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    KEY   = 2'd1,
    MULTI = 2'd2
  } scan_res_e;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } acc_state_e;

  // Layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'd0;
    if (col == 2'd3) begin
      code = KEY_A + {2'b00, row};
    end else begin
      case (row)
        2'd0:    code = 4'd1 + {2'b00, col};
        2'd1:    code = 4'd4 + {2'b00, col};
        2'd2:    code = 4'd7 + {2'b00, col};
        default: begin
          case (col)
            2'd0:    code = KEY_STAR;
            2'd1:    code = 4'd0;
            default: code = KEY_HASH;
          endcase
        end
      endcase
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_scan_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, with a configurable
// reset value so idle lines come out of reset in their inactive state.
module sync_2ff #(
  parameter int              WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: row sequencer, per-scan hit accumulation,
// whole-scan debounce and an IDLE/PRESSED accept machine emitting key strobes.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SETTLE   = 10,
  parameter int DEBOUNCE = 3
) (
  input  logic       i_clk_10mhz,
  input  logic       i_rst_n,
  input  logic [3:0] i_cols_neg,
  output logic [3:0] o_rows_neg,
  output logic [3:0] o_key,
  output logic       o_key_valid,
  output logic       o_key_held
);

  localparam int SW = $clog2(SETTLE);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [DW-1:0] DEB_MAX     = DW'(DEBOUNCE);

  logic [3:0]    cols_s;

  logic [SW-1:0] settle_q, settle_d;
  logic [1:0]    row_q, row_d;
  logic [1:0]    hits_q, hits_d;
  logic [3:0]    hit_code_q, hit_code_d;
  scan_res_e     res_q, res_d;
  logic [3:0]    res_code_q, res_code_d;
  logic          scan_end_q, scan_end_d;
  scan_res_e     prev_res_q, prev_res_d;
  logic [3:0]    prev_code_q, prev_code_d;
  logic [DW-1:0] stab_q, stab_d;
  acc_state_e    state_q, state_d;
  logic [3:0]    key_q, key_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;

  logic          sample;
  logic [1:0]    row_hits;
  logic [1:0]    row_col;
  logic [2:0]    tot3;
  logic [1:0]    tot;
  logic [3:0]    code_n;
  logic          same;
  logic          accept;

  sync_2ff #(
    .WIDTH   (4),
    .RST_VAL (4'hF)
  ) u_cols_sync (
    .clk_i  (i_clk_10mhz),
    .rst_ni (i_rst_n),
    .d_i    (i_cols_neg),
    .q_o    (cols_s)
  );

  assign sample = (settle_q == SETTLE_LAST);

  // Hits in the current row, saturating at 2 since only NONE/KEY/MULTI matter.
  always_comb begin
    row_hits = 2'd0;
    row_col  = 2'd0;
    for (int c = 0; c < 4; c++) begin
      if (!cols_s[c]) begin
        if (row_hits != 2'd2) row_hits = row_hits + 2'd1;
        row_col = 2'(c);
      end
    end
    tot3   = {1'b0, hits_q} + {1'b0, row_hits};
    tot    = (tot3 >= 3'd2) ? 2'd2 : tot3[1:0];
    code_n = (hits_q == 2'd0 && row_hits == 2'd1) ? key_code(row_q, row_col) : hit_code_q;
  end

  always_comb begin
    settle_d   = sample ? '0 : settle_q + 1'b1;
    row_d      = sample ? row_q + 2'd1 : row_q;
    hits_d     = hits_q;
    hit_code_d = hit_code_q;
    res_d      = res_q;
    res_code_d = res_code_q;
    scan_end_d = 1'b0;
    if (sample) begin
      if (row_q == 2'd3) begin
        hits_d     = 2'd0;
        hit_code_d = 4'd0;
        scan_end_d = 1'b1;
        res_code_d = code_n;
        case (tot)
          2'd0:    res_d = NONE;
          2'd1:    res_d = KEY;
          default: res_d = MULTI;
        endcase
      end else begin
        hits_d     = tot;
        hit_code_d = code_n;
      end
    end
  end

  // Debounce runs on the scan-end cycle; acceptance only on reaching DEB_MAX.
  always_comb begin
    same        = (res_q == prev_res_q) && ((res_q != KEY) || (res_code_q == prev_code_q));
    stab_d      = stab_q;
    prev_res_d  = prev_res_q;
    prev_code_d = prev_code_q;
    accept      = 1'b0;
    if (scan_end_q) begin
      prev_res_d  = res_q;
      prev_code_d = res_code_q;
      if (same) stab_d = (stab_q == DEB_MAX) ? stab_q : stab_q + 1'b1;
      else      stab_d = DW'(1);
      accept = (stab_d == DEB_MAX) && !(same && (stab_q == DEB_MAX));
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    valid_d = 1'b0;
    held_d  = held_q;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (res_q == KEY) begin
            key_d   = res_code_q;
            valid_d = 1'b1;
            held_d  = 1'b1;
            state_d = PRESSED;
          end
        end
        PRESSED: begin
          if (res_q == KEY && res_code_q != key_q) begin
            key_d   = res_code_q;
            valid_d = 1'b1;
          end else if (res_q == NONE) begin
            held_d  = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk_10mhz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      settle_q    <= '0;
      row_q       <= 2'd0;
      hits_q      <= 2'd0;
      hit_code_q  <= 4'd0;
      res_q       <= NONE;
      res_code_q  <= 4'd0;
      scan_end_q  <= 1'b0;
      prev_res_q  <= NONE;
      prev_code_q <= 4'd0;
      stab_q      <= '0;
      state_q     <= IDLE;
      key_q       <= 4'd0;
      valid_q     <= 1'b0;
      held_q      <= 1'b0;
    end else begin
      settle_q    <= settle_d;
      row_q       <= row_d;
      hits_q      <= hits_d;
      hit_code_q  <= hit_code_d;
      res_q       <= res_d;
      res_code_q  <= res_code_d;
      scan_end_q  <= scan_end_d;
      prev_res_q  <= prev_res_d;
      prev_code_q <= prev_code_d;
      stab_q      <= stab_d;
      state_q     <= state_d;
      key_q       <= key_d;
      valid_q     <= valid_d;
      held_q      <= held_d;
    end
  end

  assign o_rows_neg  = ~(4'b0001 << row_q);
  assign o_key       = key_q;
  assign o_key_valid = valid_q;
  assign o_key_held  = held_q;

endmodule
